// File: rtl/regif_tgt.sv
// regif_tgt: single-beat IP2Bus command target driving a simple user register port
module regif_tgt #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_W      = 12,
    parameter int          TIMEOUT_CYC = 64
) (
    input  logic              reg_int_clk,
    input  logic              reg_int_reset,
    input  logic              IP2Bus_MstRd_Req,
    input  logic              IP2Bus_MstWr_Req,
    input  logic [31:0]       IP2Bus_Mst_Addr,
    input  logic [3:0]        IP2Bus_Mst_BE,
    input  logic              IP2Bus_Mst_Lock,
    input  logic              IP2Bus_Mst_Reset,
    input  logic [31:0]       IP2Bus_MstWr_d,
    output logic              Bus2IP_Mst_CmdAck,
    output logic              Bus2IP_Mst_Cmplt,
    output logic              Bus2IP_Mst_Error,
    output logic              Bus2IP_Mst_Rearbitrate,
    output logic              Bus2IP_Mst_Timeout,
    output logic [31:0]       Bus2IP_MstRd_d,
    output logic              Bus2IP_MstRd_src_rdy_n,
    output logic              Bus2IP_MstWr_dst_rdy_n,
    output logic [ADDR_W-3:0] reg_addr,
    output logic [3:0]        reg_be,
    output logic [31:0]       reg_wr_data,
    output logic              reg_wr_en,
    output logic              reg_rd_en,
    input  logic [31:0]       reg_rd_data,
    input  logic              reg_ack
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, ACK, ISSUE, WAIT, CPL} state_t;

    state_t        state;
    logic          is_wr;
    logic          hit;
    logic [CW-1:0] cnt;
    logic [CW-1:0] nxt;
    logic          unused_ok;

    assign Bus2IP_Mst_Rearbitrate = 1'b0;
    assign unused_ok = &{1'b0, IP2Bus_Mst_Lock, IP2Bus_Mst_Addr[1:0]};

    // cycle count the access will have reached after this edge; ISSUE restarts it at 1
    always_comb nxt = (state == ISSUE) ? ONE : cnt + ONE;

    // command FSM with all bus and register-port outputs registered
    always_ff @(posedge reg_int_clk) begin
        if (reg_int_reset || IP2Bus_Mst_Reset) begin
            state                  <= IDLE;
            is_wr                  <= 1'b0;
            hit                    <= 1'b0;
            cnt                    <= '0;
            Bus2IP_Mst_CmdAck      <= 1'b0;
            Bus2IP_Mst_Cmplt       <= 1'b0;
            Bus2IP_Mst_Error       <= 1'b0;
            Bus2IP_Mst_Timeout     <= 1'b0;
            Bus2IP_MstRd_d         <= '0;
            Bus2IP_MstRd_src_rdy_n <= 1'b1;
            Bus2IP_MstWr_dst_rdy_n <= 1'b1;
            reg_addr               <= '0;
            reg_be                 <= '0;
            reg_wr_data            <= '0;
            reg_wr_en              <= 1'b0;
            reg_rd_en              <= 1'b0;
        end else begin
            Bus2IP_Mst_CmdAck      <= 1'b0;
            Bus2IP_Mst_Cmplt       <= 1'b0;
            Bus2IP_Mst_Error       <= 1'b0;
            Bus2IP_Mst_Timeout     <= 1'b0;
            Bus2IP_MstRd_src_rdy_n <= 1'b1;
            Bus2IP_MstWr_dst_rdy_n <= 1'b1;
            reg_wr_en              <= 1'b0;
            reg_rd_en              <= 1'b0;
            case (state)
                IDLE: if (IP2Bus_MstWr_Req || IP2Bus_MstRd_Req) begin
                    is_wr                  <= IP2Bus_MstWr_Req;
                    hit                    <= IP2Bus_Mst_Addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W];
                    reg_addr               <= IP2Bus_Mst_Addr[ADDR_W-1:2];
                    reg_be                 <= IP2Bus_Mst_BE;
                    reg_wr_data            <= IP2Bus_MstWr_d;
                    Bus2IP_Mst_CmdAck      <= 1'b1;
                    Bus2IP_MstWr_dst_rdy_n <= ~IP2Bus_MstWr_Req;
                    state                  <= ACK;
                end
                ACK: if (hit) begin
                    reg_wr_en <= is_wr;
                    reg_rd_en <= ~is_wr;
                    state     <= ISSUE;
                end else begin
                    Bus2IP_Mst_Cmplt <= 1'b1;
                    Bus2IP_Mst_Error <= 1'b1;
                    if (!is_wr) Bus2IP_MstRd_d <= 32'hFFFF_FFFF;
                    state <= CPL;
                end
                ISSUE, WAIT: begin
                    cnt <= nxt;
                    if (reg_ack) begin
                        Bus2IP_Mst_Cmplt <= 1'b1;
                        if (!is_wr) begin
                            Bus2IP_MstRd_d         <= reg_rd_data;
                            Bus2IP_MstRd_src_rdy_n <= 1'b0;
                        end
                        state <= CPL;
                    end else if (nxt == TMO) begin
                        Bus2IP_Mst_Cmplt   <= 1'b1;
                        Bus2IP_Mst_Error   <= 1'b1;
                        Bus2IP_Mst_Timeout <= 1'b1;
                        if (!is_wr) Bus2IP_MstRd_d <= 32'hFFFF_FFFF;
                        state <= CPL;
                    end else begin
                        state <= WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regif_tgt.sv
// tb_regif_tgt: directed self-checking bench for regif_tgt
module tb_regif_tgt;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0, wr_req = 1'b0, lock = 1'b0, mst_rst = 1'b0;
    logic [31:0] addr = '0, wr_d = '0, rd_data = '0;
    logic [3:0]  be = '0;
    logic        ack = 1'b0;
    logic        cmd_ack, cmplt, err, rearb, tmo, src_n, dst_n, wr_en, rd_en;
    logic [31:0] rd_d, reg_wr_data;
    logic [9:0]  reg_addr;
    logic [3:0]  reg_be;
    int          n_cmp = 0;
    int          n_bad = 0;

    regif_tgt #(.BASE_ADDR(32'h0), .ADDR_W(12), .TIMEOUT_CYC(64)) dut (
        .reg_int_clk(clk), .reg_int_reset(rst),
        .IP2Bus_MstRd_Req(rd_req), .IP2Bus_MstWr_Req(wr_req),
        .IP2Bus_Mst_Addr(addr), .IP2Bus_Mst_BE(be), .IP2Bus_Mst_Lock(lock),
        .IP2Bus_Mst_Reset(mst_rst), .IP2Bus_MstWr_d(wr_d),
        .Bus2IP_Mst_CmdAck(cmd_ack), .Bus2IP_Mst_Cmplt(cmplt), .Bus2IP_Mst_Error(err),
        .Bus2IP_Mst_Rearbitrate(rearb), .Bus2IP_Mst_Timeout(tmo),
        .Bus2IP_MstRd_d(rd_d), .Bus2IP_MstRd_src_rdy_n(src_n), .Bus2IP_MstWr_dst_rdy_n(dst_n),
        .reg_addr(reg_addr), .reg_be(reg_be), .reg_wr_data(reg_wr_data),
        .reg_wr_en(wr_en), .reg_rd_en(rd_en), .reg_rd_data(rd_data), .reg_ack(ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // read with ack in the strobe cycle; returns in the CPL cycle
    task automatic rd_txn(input string tag, input logic [31:0] a, input logic [31:0] d);
        addr = a; rd_req = 1'b1;
        tick();
        chk({tag, "_cmdack"}, {31'b0, cmd_ack}, 32'd1);
        tick();
        rd_req = 1'b0;
        chk({tag, "_rden"}, {31'b0, rd_en}, 32'd1);
        ack = 1'b1; rd_data = d;
        tick();
        ack = 1'b0;
        chk({tag, "_cmplt"}, {31'b0, cmplt}, 32'd1);
        chk({tag, "_src"}, {31'b0, src_n}, 32'd0);
        chk({tag, "_data"}, rd_d, d);
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        rst = 1'b0;
        chk("rst_cmdack", {31'b0, cmd_ack}, 32'd0);
        chk("rst_cmplt", {31'b0, cmplt}, 32'd0);
        chk("rst_rdy", {30'b0, src_n, dst_n}, 32'd3);
        chk("rst_rdd", rd_d, 32'd0);
        chk("rst_regs", {22'b0, reg_addr}, 32'd0);
        chk("rst_rearb", {31'b0, rearb}, 32'd0);

        // hit write, ack in strobe cycle
        addr = 32'h10; be = 4'hF; wr_d = 32'hCAFEBABE; wr_req = 1'b1;
        tick();
        chk("wr_cmdack", {31'b0, cmd_ack}, 32'd1);
        chk("wr_dst", {31'b0, dst_n}, 32'd0);
        tick();
        wr_req = 1'b0;
        chk("wr_en", {31'b0, wr_en}, 32'd1);
        chk("wr_addr", {22'b0, reg_addr}, 32'd4);
        chk("wr_data", reg_wr_data, 32'hCAFEBABE);
        chk("wr_be", {28'b0, reg_be}, 32'hF);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("wr_cmplt", {31'b0, cmplt}, 32'd1);
        chk("wr_err", {31'b0, err}, 32'd0);
        chk("wr_en_off", {31'b0, wr_en}, 32'd0);
        tick();

        // hit read, ack in cycle 5
        addr = 32'h24; be = 4'h6; rd_req = 1'b1;
        tick();
        chk("rd_cmdack", {31'b0, cmd_ack}, 32'd1);
        chk("rd_dst", {31'b0, dst_n}, 32'd1);
        tick();
        rd_req = 1'b0;
        chk("rd_en", {31'b0, rd_en}, 32'd1);
        chk("rd_addr", {22'b0, reg_addr}, 32'd9);
        chk("rd_be", {28'b0, reg_be}, 32'h6);
        tick();
        chk("rd_en_once", {31'b0, rd_en}, 32'd0);
        tick();
        chk("rd_c4", {31'b0, cmplt}, 32'd0);
        tick();
        ack = 1'b1; rd_data = 32'h1234_5678;
        chk("rd_c5", {31'b0, cmplt}, 32'd0);
        tick();
        ack = 1'b0;
        chk("rd_cmplt", {31'b0, cmplt}, 32'd1);
        chk("rd_src", {31'b0, src_n}, 32'd0);
        chk("rd_data", rd_d, 32'h1234_5678);
        chk("rd_err", {31'b0, err}, 32'd0);
        tick();

        // decode miss
        addr = 32'h0000_1000; rd_req = 1'b1;
        tick();
        chk("miss_cmdack", {31'b0, cmd_ack}, 32'd1);
        tick();
        rd_req = 1'b0;
        chk("miss_cmplt", {31'b0, cmplt}, 32'd1);
        chk("miss_err", {31'b0, err}, 32'd1);
        chk("miss_tmo", {31'b0, tmo}, 32'd0);
        chk("miss_src", {31'b0, src_n}, 32'd1);
        chk("miss_data", rd_d, 32'hFFFF_FFFF);
        chk("miss_nostrobe", {30'b0, wr_en, rd_en}, 32'd0);
        tick();

        // timeout with no ack
        addr = 32'h30; rd_data = 32'h0; rd_req = 1'b1;
        tick();
        tick();
        rd_req = 1'b0;
        chk("to_rden", {31'b0, rd_en}, 32'd1);
        repeat (63) tick();
        chk("to_c65", {30'b0, cmplt, tmo}, 32'd0);
        tick();
        chk("to_cmplt", {31'b0, cmplt}, 32'd1);
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_tmo", {31'b0, tmo}, 32'd1);
        chk("to_src", {31'b0, src_n}, 32'd1);
        chk("to_data", rd_d, 32'hFFFF_FFFF);
        tick();
        ack = 1'b1;
        tick();
        tick();
        ack = 1'b0;
        chk("stray_ack", {28'b0, cmd_ack, cmplt, wr_en, rd_en}, 32'd0);

        // simultaneous requests: write first, read accepted in cycle 5
        addr = 32'h40; wr_d = 32'h0000_55AA; be = 4'hF; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        chk("both_cmdack1", {31'b0, cmd_ack}, 32'd1);
        chk("both_dst", {31'b0, dst_n}, 32'd0);
        tick();
        wr_req = 1'b0;
        chk("both_wren", {30'b0, wr_en, rd_en}, 32'd2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("both_wcmplt", {31'b0, cmplt}, 32'd1);
        tick();
        chk("both_c4", {31'b0, cmd_ack}, 32'd0);
        tick();
        chk("both_cmdack2", {31'b0, cmd_ack}, 32'd1);
        chk("both_dst2", {31'b0, dst_n}, 32'd1);
        tick();
        rd_req = 1'b0;
        chk("both_rden", {30'b0, wr_en, rd_en}, 32'd1);
        ack = 1'b1; rd_data = 32'h0000_A5A5;
        tick();
        ack = 1'b0;
        chk("both_rcmplt", {31'b0, cmplt}, 32'd1);
        chk("both_rdata", rd_d, 32'h0000_A5A5);
        tick();

        // command abort during WAIT
        addr = 32'h50; rd_req = 1'b1;
        tick();
        tick();
        rd_req = 1'b0;
        tick();
        mst_rst = 1'b1;
        tick();
        mst_rst = 1'b0;
        chk("mrst_out", {29'b0, cmplt, cmd_ack, rd_en}, 32'd0);
        chk("mrst_regs", {22'b0, reg_addr}, 32'd0);
        chk("mrst_rdd", rd_d, 32'd0);
        repeat (4) tick();
        chk("mrst_nocpl", {31'b0, cmplt}, 32'd0);
        rd_txn("mrst_after", 32'h54, 32'h0BAD_F00D);

        // sync reset during WAIT
        addr = 32'h58; rd_req = 1'b1;
        tick();
        tick();
        rd_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("srst_out", {29'b0, cmplt, cmd_ack, rd_en}, 32'd0);
        chk("srst_rdy", {30'b0, src_n, dst_n}, 32'd3);
        chk("srst_rdd", rd_d, 32'd0);
        repeat (4) tick();
        chk("srst_nocpl", {31'b0, cmplt}, 32'd0);
        rd_txn("srst_after", 32'h5C, 32'h8765_4321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
